// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage control and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [4:0]       ALUcontrol;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] ALUresult;
    logic             Zero;
    logic             Sign;
    logic             illegal;

    modport master (
        output start, flush, ALUcontrol, SrcA, SrcB,
        input  ready, done, ALUresult, Zero, Sign, illegal
    );

    modport slave (
        input  start, flush, ALUcontrol, SrcA, SrcB,
        output ready, done, ALUresult, Zero, Sign, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: RV32I base ops in one cycle, RV32M mul/div one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] result;
    logic             illegal_q;

    // iteration registers: hi/lo hold acc:multiplier or remainder:quotient
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
    logic [2:0]       mop;
    logic             neg;
    logic             div0;

    logic ready, accept, is_m;
    assign ready  = (state != RUN);
    assign accept = bus.start && ready && !bus.flush;
    assign is_m   = (bus.ALUcontrol[4:3] == 2'b10);

    assign bus.ready     = ready;
    assign bus.done      = (state == DONE);
    assign bus.ALUresult = result;
    assign bus.Zero      = (result == '0);
    assign bus.Sign      = result[WIDTH-1];
    assign bus.illegal   = illegal_q;

    // single-cycle base operations and illegal-code detection
    logic [WIDTH-1:0] base_res;
    logic             base_ill;
    logic [SHW-1:0]   shamt;
    assign shamt = bus.SrcB[SHW-1:0];
    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (bus.ALUcontrol)
            5'b00000: base_res = bus.SrcA + bus.SrcB;
            5'b00001: base_res = bus.SrcA - bus.SrcB;
            5'b00010: base_res = bus.SrcA & bus.SrcB;
            5'b00011: base_res = bus.SrcA | bus.SrcB;
            5'b00100: base_res = bus.SrcA << shamt;
            5'b00101: base_res[0] = ($signed(bus.SrcA) < $signed(bus.SrcB));
            5'b00110: base_res = bus.SrcA ^ bus.SrcB;
            5'b00111: base_res = bus.SrcA >> shamt;
            5'b01000: base_res[0] = (bus.SrcA < bus.SrcB);
            5'b01111: base_res = $unsigned($signed(bus.SrcA) >>> shamt);
            default:  base_ill = 1'b1;
        endcase
    end

    // operand magnitudes and result sign for an M op at accept
    logic             sa, sb, a_neg, b_neg, neg_n;
    logic [WIDTH-1:0] a_mag, b_mag;
    always_comb begin
        if (!bus.ALUcontrol[2]) begin
            sa = (bus.ALUcontrol[1:0] == 2'b01) || (bus.ALUcontrol[1:0] == 2'b10);
            sb = (bus.ALUcontrol[1:0] == 2'b01);
        end else begin
            sa = !bus.ALUcontrol[0];
            sb = !bus.ALUcontrol[0];
        end
        a_neg = sa && bus.SrcA[WIDTH-1];
        b_neg = sb && bus.SrcB[WIDTH-1];
        a_mag = a_neg ? -bus.SrcA : bus.SrcA;
        b_mag = b_neg ? -bus.SrcB : bus.SrcB;
        // remainder takes the dividend's sign; everything else the xor
        neg_n = (bus.ALUcontrol[2] && bus.ALUcontrol[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // one shift-add (mul) or restoring shift-subtract (div) step
    logic [WIDTH:0]   sum, shifted, hi_n;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] lo_n;
    always_comb begin
        sum     = hi + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        if (!mop[2]) begin
            hi_n = {1'b0, sum[WIDTH:1]};
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            hi_n = diff[WIDTH:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = shifted;
            lo_n = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // sign fix-up and half selection once iteration is complete
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   rem_mag, fin_res;
    assign prod    = {hi[WIDTH-1:0], lo};
    assign prod_s  = neg ? -prod : prod;
    assign rem_mag = hi[WIDTH-1:0];
    always_comb begin
        fin_res = '0;
        if (!mop[2])
            fin_res = (mop[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        else if (mop[1])
            fin_res = neg ? -rem_mag : rem_mag;
        else if (div0)
            fin_res = '1;   // quotient of x/0 is all ones regardless of sign
        else
            fin_res = neg ? -lo : lo;
    end

    // control FSM and architecturally visible result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept && is_m) begin
                        state <= RUN;
                    end else if (accept) begin
                        state     <= DONE;
                        result    <= base_res;
                        illegal_q <= base_ill;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state     <= DONE;
                        result    <= fin_res;
                        illegal_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // iteration datapath: load magnitudes at accept, step while counting down
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            opb  <= '0;
            cnt  <= '0;
            mop  <= '0;
            neg  <= 1'b0;
            div0 <= 1'b0;
        end else if (accept && is_m) begin
            hi   <= '0;
            lo   <= a_mag;
            opb  <= b_mag;
            cnt  <= CW'(WIDTH);
            mop  <= bus.ALUcontrol[2:0];
            neg  <= neg_n;
            div0 <= bus.ALUcontrol[2] && (bus.SrcB == '0);
        end else if (state == RUN && !bus.flush && cnt != '0) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle successor to the core's combinational ALU.
- Executes the existing RV32I ALU operations plus the RV32M multiply/divide group.
- Sits in EX behind a start/ready handshake, so the control FSM can stall on long operations.
- Base ops complete in 1 cycle; MUL/DIV iterate one bit per cycle.

Parameters:
- WIDTH, 32, datapath width; must be a power of two, at least 8.
- SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- flush  in  1  synchronous abort of any in-flight operation.
- ALUcontrol  in  5  operation code; sampled at accept.
- SrcA  in  WIDTH  operand A; sampled at accept.
- SrcB  in  WIDTH  operand B; sampled at accept.
- ready  out  1  high in IDLE and DONE.
- done  out  1  one-cycle pulse: result valid.
- ALUresult  out  WIDTH  registered result; held until the next accept.
- Zero  out  1  high when ALUresult is all zeros.
- Sign  out  1  ALUresult[WIDTH-1].
- illegal  out  1  registered with done; high for an undefined opcode.

Behaviour:
- Reset values: ready=1, done=0, ALUresult=0, Zero=1, Sign=0, illegal=0; state=IDLE.
- Base opcodes (bit4=0):
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR.
  - 00100 SLL, 00101 SLT (signed), 00110 XOR, 00111 SRL.
  - 01000 SLTU, 01111 SRA.
  - Shifts use SrcB[SHW-1:0] only.
  - SLT/SLTU return a WIDTH-bit value with bit0=result and all other bits 0.
- M opcodes:
  - 10000 MUL (low half), 10001 MULH (signed x signed, high half).
  - 10010 MULHSU (signed A x unsigned B, high half), 10011 MULHU (high half).
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other code: ALUresult=0, illegal=1, base-op latency.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with accept of a base or illegal op: result computed and registered at the accept edge; next state DONE; done=1 for the following cycle.
  - Accept of an M op: operands converted to magnitudes per signedness; counter=WIDTH; next state RUN; ready=0.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - When counter reaches 0: sign fix-up, result registered, go to DONE. done pulses exactly WIDTH+1 cycles after the accept edge.
  - DONE with no accept: return to IDLE; result is held.
- Back-to-back: an accept during DONE is legal; done may be high on consecutive cycles.
- start while ready=0 is ignored; no queuing.
- Division by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = SrcA.
  - Full WIDTH+1 latency is still taken; latency is constant per class.
- Signed overflow (DIV of most-negative by -1): quotient = SrcA, REM = 0; latency unchanged.
- Multiply sign fix-up: the 2*WIDTH product is negated when operand signs differ (per op signedness); MULHSU treats B as unsigned.
- flush:
  - In RUN: return to IDLE next edge; no done; ALUresult keeps its previous value.
  - flush with start in the same cycle: flush wins and nothing is accepted.
  - In IDLE/DONE: state forced to IDLE; done suppressed.
- reset mid-RUN: immediate return to reset values; no done is produced.
- Zero and Sign are combinational from the registered ALUresult and valid at all times.

Test Plan:
1. Reset, then ADD SrcA=0x7FFFFFFF, SrcB=1 -> done one cycle later, ALUresult=0x80000000, Sign=1, Zero=0. SUB 5-5 -> ALUresult=0, Zero=1.
2. SRA SrcA=0x80000000, SrcB=0x24 -> shift by 4, ALUresult=0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT same operands -> 0.
3. MULH 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 33 cycles after accept, ALUresult=0. MULHU same operands -> 0xFFFFFFFE, ready=0 throughout RUN. MUL -7 x 3 -> 0xFFFFFFEB.
4. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 10. DIV 0x80000000/-1 -> 0x80000000; REM of same -> 0.
5. Start DIVU, flush at cycle 10 -> no done, ready=1 next cycle, ALUresult unchanged. Repeat with reset mid-RUN -> all outputs at reset values asynchronously.
6. ALUcontrol=11111 -> done after one cycle, illegal=1, ALUresult=0. Back-to-back ADD accepted in DONE -> done high two consecutive cycles.
